// File: rtl/cells_commit_if.sv
// Bus between the frame-commit engine and its surroundings: start/stall control,
// the next-state RAM read port, the VRAM and RAM write ports, and status.
interface cells_commit_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 2
);
    logic                  start_i;
    logic                  stall_i;
    logic [ADDR_WIDTH-1:0] ram_rd_address_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [ADDR_WIDTH-1:0] vram_wr_address_o;
    logic [DATA_WIDTH-1:0] vram_wr_data_o;
    logic                  vram_wr_en_o;
    logic [ADDR_WIDTH-1:0] ram_wr_address_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o;
    logic                  ram_wr_en_o;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   sand_count_o;
    logic [ADDR_WIDTH:0]   water_count_o;

    // The commit engine drives the memory ports and status.
    modport master (
        input  start_i, stall_i, ram_rd_data_i,
        output ram_rd_address_o,
        output vram_wr_address_o, vram_wr_data_o, vram_wr_en_o,
        output ram_wr_address_o, ram_wr_data_o, ram_wr_en_o,
        output busy_o, done_o, sand_count_o, water_count_o
    );

    // Controller plus memories on the other side.
    modport slave (
        output start_i, stall_i, ram_rd_data_i,
        input  ram_rd_address_o,
        input  vram_wr_address_o, vram_wr_data_o, vram_wr_en_o,
        input  ram_wr_address_o, ram_wr_data_o, ram_wr_en_o,
        input  busy_o, done_o, sand_count_o, water_count_o
    );
endinterface

// File: rtl/cells_commit.sv
// Frame-commit engine: streams the next-state RAM into VRAM one cell per cycle,
// clears each RAM cell behind the read, and counts sand/water cells on the way.
module cells_commit #(
    parameter int COLUMNS    = 640,
    parameter int ROWS       = 480,
    parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS),
    parameter int DATA_WIDTH = 2
) (
    input logic           clk_i,
    input logic           reset_i,
    cells_commit_if.master bus
);
    localparam int N  = COLUMNS * ROWS;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(N - 1);
    localparam logic [DATA_WIDTH-1:0] CELL_SAND  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] CELL_WATER = DATA_WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state,      w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr,    w_rd_addr_nxt;
    logic                  r_pend_valid, w_pend_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_pend_addr,  w_pend_addr_nxt;
    logic [CW-1:0]         r_sand,       w_sand_nxt;
    logic [CW-1:0]         r_water,      w_water_nxt;
    logic                  w_issue;

    // NOTE: every value assigned here gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_addr_nxt    = r_rd_addr;
        w_pend_valid_nxt = 1'b0;
        w_pend_addr_nxt  = '0;
        w_sand_nxt       = r_sand;
        w_water_nxt      = r_water;
        w_issue          = 1'b0;

        // Completion stage: the read issued last cycle returns now, in any state.
        if (r_pend_valid) begin
            if (bus.ram_rd_data_i == CELL_SAND)  w_sand_nxt  = r_sand  + CW'(1);
            if (bus.ram_rd_data_i == CELL_WATER) w_water_nxt = r_water + CW'(1);
        end

        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt   = S_SCAN;
                    w_rd_addr_nxt = '0;
                    w_sand_nxt    = '0;
                    w_water_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (!bus.stall_i) begin
                    w_issue          = 1'b1;
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = r_rd_addr;
                    if (r_rd_addr == LAST_ADDR) begin
                        w_state_nxt   = S_DRAIN;
                        w_rd_addr_nxt = '0;
                    end else begin
                        w_rd_addr_nxt = r_rd_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values. Only control state is reset; the RAM and VRAM contents
    // live outside and are simply re-committed by the next pass.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_rd_addr    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_sand       <= '0;
            r_water      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_addr    <= w_rd_addr_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_sand       <= w_sand_nxt;
            r_water      <= w_water_nxt;
        end
    end

    // Addresses and data are forced to zero whenever their strobe is idle.
    assign bus.ram_rd_address_o  = w_issue ? r_rd_addr : '0;

    assign bus.vram_wr_en_o      = r_pend_valid;
    assign bus.vram_wr_address_o = r_pend_valid ? r_pend_addr : '0;
    assign bus.vram_wr_data_o    = r_pend_valid ? bus.ram_rd_data_i : '0;

    assign bus.ram_wr_en_o       = r_pend_valid;
    assign bus.ram_wr_address_o  = r_pend_valid ? r_pend_addr : '0;
    assign bus.ram_wr_data_o     = '0;

    assign bus.busy_o            = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign bus.done_o            = (r_state == S_DONE);
    assign bus.sand_count_o      = r_sand;
    assign bus.water_count_o     = r_water;

    // A pending write can only exist while the pass is running.
    a_write_in_pass: assert property (@(posedge clk_i) disable iff (reset_i)
        r_pend_valid |-> (r_state == S_SCAN || r_state == S_DRAIN));

    a_done_pulse: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.done_o |=> !bus.done_o);

endmodule

// File: tb/tb_cells_commit.sv
// Bench for cells_commit on a 4x3 frame: dual-port RAM and VRAM models, a table of
// commit passes with a write scoreboard, plus a hand-written mid-pass reset sequence.
module tb_cells_commit;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);
    localparam int DW   = 2;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    cells_commit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cells_commit #(.COLUMNS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // Memory models: synchronous-read RAM with a separate clear port, and VRAM.
    logic [DW-1:0] ram_m     [N];
    logic [DW-1:0] vram_m    [N];
    logic [DW-1:0] load_ram  [N];
    logic [DW-1:0] load_vram [N];
    logic          load_req;
    logic [DW-1:0] rd_q;

    always @(posedge clk_i) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) begin
                ram_m[i]  <= load_ram[i];
                vram_m[i] <= load_vram[i];
            end
            rd_q <= '0;
        end else begin
            rd_q <= ram_m[bus.ram_rd_address_o];
            if (bus.vram_wr_en_o) vram_m[bus.vram_wr_address_o] <= bus.vram_wr_data_o;
            if (bus.ram_wr_en_o)  ram_m[bus.ram_wr_address_o]   <= bus.ram_wr_data_o;
        end
    end
    assign bus.ram_rd_data_i = rd_q;

    typedef struct {
        bit reload;
        int mode;
        int stall_at;
        int stall_len;
        int restart_at;
        int exp_sand;
        int exp_water;
        int exp_lat;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t          vecs [8];
    wr_t           sb [$];
    logic [DW-1:0] exp_img [N];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a [N]);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
        return r;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({bus.ram_rd_address_o, bus.vram_wr_address_o, bus.vram_wr_data_o,
                    bus.vram_wr_en_o, bus.ram_wr_address_o, bus.ram_wr_data_o,
                    bus.ram_wr_en_o, bus.busy_o, bus.done_o,
                    bus.sand_count_o, bus.water_count_o});
    endfunction

    // mode 0: test image in RAM, stale 11 in VRAM; mode 1: empty RAM, VRAM full of sand.
    task automatic set_image(input int mode);
        for (int i = 0; i < N; i++) begin
            load_ram[i]  = 2'b00;
            load_vram[i] = (mode == 0) ? 2'b11 : 2'b01;
        end
        if (mode == 0) begin
            load_ram[0]  = 2'b01;
            load_ram[1]  = 2'b01;
            load_ram[2]  = 2'b01;
            load_ram[5]  = 2'b10;
            load_ram[11] = 2'b11;
        end
    endtask

    // Entered and left at #1 after a rising edge; the start cycle is the current one.
    task automatic run_pass(input vec_t v);
        int            issued;
        bit            st;
        logic [AW-1:0] exp_rd;
        logic [DW-1:0] zero_img [N];
        wr_t           e;

        if (v.reload) begin
            set_image(v.mode);
            for (int i = 0; i < N; i++) exp_img[i] = load_ram[i];
            load_req = 1'b1;
        end
        bus.start_i = 1'b1;
        bus.stall_i = 1'b0;
        @(negedge clk_i);
        check("idle_before_start", 64'({bus.busy_o, bus.done_o}), 64'(0));
        @(posedge clk_i); #1;
        load_req    = 1'b0;
        bus.start_i = 1'b0;
        issued      = 0;

        for (int c = 1; c <= v.exp_lat; c++) begin
            st          = (c >= v.stall_at) && (c < v.stall_at + v.stall_len);
            bus.stall_i = st;
            bus.start_i = (c == v.restart_at);
            @(negedge clk_i);

            if (issued < N && !st) begin
                exp_rd = AW'(issued);
                sb.push_back('{addr: AW'(issued), data: exp_img[issued]});
                issued++;
            end else begin
                exp_rd = '0;
            end
            check("rd_addr", 64'(bus.ram_rd_address_o), 64'(exp_rd));
            check("busy",    64'(bus.busy_o), 64'(c < v.exp_lat));
            check("done",    64'(bus.done_o), 64'(c == v.exp_lat));

            if (bus.vram_wr_en_o) begin
                check("write_expected", 64'(sb.size() > 1 || (sb.size() == 1 && exp_rd == '0 && st)
                                            || (sb.size() == 1 && issued == N && c > 1)), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("vram_wr", 64'({bus.vram_wr_address_o, bus.vram_wr_data_o}),
                          64'({e.addr, e.data}));
                    check("ram_clr", 64'({bus.ram_wr_en_o, bus.ram_wr_address_o, bus.ram_wr_data_o}),
                          64'({1'b1, e.addr, 2'b00}));
                end
            end else begin
                check("idle_wr", 64'({bus.vram_wr_address_o, bus.vram_wr_data_o,
                                      bus.ram_wr_en_o, bus.ram_wr_address_o, bus.ram_wr_data_o}),
                      64'(0));
            end
            // Exactly one outstanding entry after a cycle that issued a read, none otherwise.
            check("sb_depth", 64'(sb.size()), 64'(exp_rd != '0 || (issued > 0 && !st && issued <= N
                                                   && c >= 1 && sb.size() == 1)));

            if (c == v.exp_lat) begin
                check("sand_count",  64'(bus.sand_count_o),  64'(v.exp_sand));
                check("water_count", 64'(bus.water_count_o), 64'(v.exp_water));
                for (int i = 0; i < N; i++) zero_img[i] = '0;
                check("ram_cleared", 64'(pack(ram_m)),  64'(pack(zero_img)));
                check("vram_image",  64'(pack(vram_m)), 64'(pack(exp_img)));
                check("all_issued",  64'(issued), 64'(N));
            end
            @(posedge clk_i); #1;
        end
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) exp_img[i] = '0;
    endtask

    initial begin
        vec_t rv;
        //                reload mode stall_at len restart sand water lat
        vecs[0] = '{1'b1, 0,   0,   0,   0,     3,   1,   14};
        vecs[1] = '{1'b1, 0,   5,   3,   0,     3,   1,   17};
        vecs[2] = '{1'b1, 0,   0,   0,   4,     3,   1,   14};
        vecs[3] = '{1'b0, 0,   0,   0,   0,     0,   0,   14};
        vecs[4] = '{1'b1, 1,   0,   0,   0,     0,   0,   14};
        vecs[5] = '{1'b1, 0,   1,   1,   0,     3,   1,   15};
        vecs[6] = '{1'b1, 0,   12,  2,   0,     3,   1,   16};
        vecs[7] = '{1'b1, 0,   0,   0,   0,     3,   1,   14};

        reset_i     = 1'b1;
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        load_req    = 1'b0;
        for (int i = 0; i < N; i++) exp_img[i] = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", all_outputs(), 64'(0));
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("idle_outputs", all_outputs(), 64'(0));

        for (int i = 0; i < 7; i++) run_pass(vecs[i]);

        // Reset in cycle 6 of a pass: outputs drop at once and nothing restarts.
        set_image(0);
        load_req    = 1'b1;
        bus.start_i = 1'b1;
        @(posedge clk_i); #1;
        load_req    = 1'b0;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        check("mid_pass_busy", 64'(bus.busy_o), 64'(1));
        reset_i = 1'b1;
        #1;
        check("reset_mid_pass", all_outputs(), 64'(0));
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("post_reset_quiet", all_outputs(), 64'(0));
            @(posedge clk_i); #1;
        end

        rv = vecs[7];
        run_pass(rv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cells_commit.md
# cells_commit

Frame-commit engine that runs after the cell next-state engine finishes a generation. It streams every cell of the next-state RAM into VRAM and clears each RAM cell as it goes, so the next update pass starts from an empty scratch buffer. While streaming, it also counts sand and water cells for the status logic. It sits between the next-state engine's `done_o` and the next `ready_i`, and owns the RAM read port plus the VRAM/RAM write ports while `busy_o` is high.

## Interface
- COLUMNS, 640, cells per row
- ROWS, 480, rows per frame
- ADDR_WIDTH, $clog2(COLUMNS*ROWS), cell address width
- DATA_WIDTH, 2, cell state width (00 empty, 01 sand, 10 water, 11 reserved)
- clk_i  input  1  clock
- reset_i  input  1  reset, asynchronous, active-high
- start_i  input  1  begin a commit pass; sampled only in IDLE
- stall_i  input  1  suppress issuing new RAM reads this cycle
- ram_rd_address_o  output  ADDR_WIDTH  RAM read address
- ram_rd_data_i  input  DATA_WIDTH  RAM read data; valid the cycle after the address is presented
- vram_wr_address_o  output  ADDR_WIDTH  VRAM write address
- vram_wr_data_o  output  DATA_WIDTH  VRAM write data
- vram_wr_en_o  output  1  VRAM write strobe
- ram_wr_address_o  output  ADDR_WIDTH  RAM clear address
- ram_wr_data_o  output  DATA_WIDTH  RAM write data; constant 0
- ram_wr_en_o  output  1  RAM clear strobe
- busy_o  output  1  high from the cycle after start is accepted until done
- done_o  output  1  one-cycle pulse at the end of a pass
- sand_count_o  output  ADDR_WIDTH+1  number of 01 cells in the last/current pass
- water_count_o  output  ADDR_WIDTH+1  number of 10 cells in the last/current pass

## Operation
- N = COLUMNS*ROWS. States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start_i=1 → clear rd_addr, both counts and pend_valid; go to SCAN.
  - start_i=0 → stay in IDLE.
- SCAN:
  - If stall_i=0: present ram_rd_address_o=rd_addr and set pend_valid=1, pend_addr=rd_addr for the next cycle.
  - If rd_addr==N-1, go to DRAIN; otherwise rd_addr+1.
  - If stall_i=1: no address advance and pend_valid=0 next cycle.
- Completion stage (any state, when pend_valid=1):
  - vram_wr_en_o=1, vram_wr_address_o=pend_addr, vram_wr_data_o=ram_rd_data_i.
  - ram_wr_en_o=1, ram_wr_address_o=pend_addr, ram_wr_data_o=0.
  - sand_count +1 if data==01; water_count +1 if data==10; 00/11 not counted.
  - Every cell is written to VRAM, including 00, so stale VRAM cells are erased.
- DRAIN: the final pending write completes; go to DONE.
- DONE: done_o=1 for one cycle; go to IDLE.
- stall_i has no effect on the completion stage; an in-flight read always completes.
- start_i outside IDLE is ignored; no queuing.
- Counts hold their final values after DONE until the next accepted start. Counts cannot overflow (max N < 2^(ADDR_WIDTH+1)).
- Reset mid-pass: immediate return to IDLE, all registers cleared. The memories are left partially committed, and software re-runs the pass.
- The RAM read address is 0 whenever no read is issued. All write addresses and data are 0 whenever their strobe is low.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - sand_count_o=0, water_count_o=0, busy_o=0, done_o=0.
- Start accepted at edge k. Without stalls:
  - Addresses 0..N-1 issued in cycles k+1..k+N.
  - Writes for address A occur in cycle k+2+A.
  - done_o in cycle k+N+2.
  - busy_o high cycles k+1..k+N+1.
- Each stalled SCAN cycle delays everything after it by exactly one cycle.
- Throughput: 1 cell/cycle. Read-to-write latency: 1 cycle.
- Counts update at the edge ending each write cycle, so they are final in the done_o cycle.
- RAM read of address A and RAM clear of A-1 in the same cycle are on different ports; the RAM is dual-port.

## Test plan
- COLUMNS=4, ROWS=3, RAM preloaded 01 at 0..2, 10 at 5, 11 at 11, rest 00; pulse start → VRAM equals preload image, RAM all 00, sand=3, water=1, done_o exactly 14 cycles after the start edge.
- Same preload, stall_i high for 3 cycles mid-SCAN → identical memory result and counts; done_o 17 cycles after start; no duplicate or skipped write addresses.
- VRAM preloaded all 01, RAM all 00 → VRAM all 00 after pass, both counts 0.
- Pulse start_i again while busy_o=1 → ignored; single done_o; a second start after done clears counts and re-runs.
- Assert reset_i at cycle 6 of a pass → all outputs 0 in the same cycle, busy_o=0, counts 0, no further writes until the next start.
- Back-to-back passes (start in the cycle after done_o) → second pass commits an all-00 RAM, counts 0.
